// File: rtl/ama_riscv_fetch_buf_if.sv
// Handshake bundle between instruction fetch, the fetch buffer and decode.
// The slave modport is the buffer's view; master is the fetch/decode side.
interface ama_riscv_fetch_buf_if;
  logic        imem_valid;
  logic [31:0] imem_inst;
  logic [31:0] imem_pc;
  logic        imem_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        flush;

  modport slave (
    input  imem_valid, imem_inst, imem_pc, id_ready, flush,
    output imem_ready, id_valid, id_inst, id_pc
  );

  modport master (
    output imem_valid, imem_inst, imem_pc, id_ready, flush,
    input  imem_ready, id_valid, id_inst, id_pc
  );
endinterface

// File: rtl/ama_riscv_fetch_buf.sv
// Circular instruction FIFO between imem and decode; absorbs decode stalls,
// drops everything on flush and shows a NOP bubble whenever it is empty.
module ama_riscv_fetch_buf #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  ama_riscv_fetch_buf_if.slave   bus,
  output logic [31:0]            bubble_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [31:0]   bubble_cnt_q, bubble_cnt_d;
  logic          push, pop;

  // A full buffer refuses a push even if the head is popped this cycle.
  assign bus.imem_ready = ~rst & (count_q != FULL);
  assign bus.id_valid   = (count_q != '0);
  assign bus.id_inst    = bus.id_valid ? inst_mem[rd_ptr_q] : NOP_INST;
  assign bus.id_pc      = bus.id_valid ? pc_mem[rd_ptr_q]   : 32'h0;
  assign bubble_cnt     = bubble_cnt_q;

  assign push = bus.imem_valid & bus.imem_ready & ~bus.flush;
  assign pop  = bus.id_valid & bus.id_ready & ~bus.flush;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    bubble_cnt_d = bubble_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (bus.id_ready && !bus.id_valid && !bus.flush)
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  // Flush and reset both empty the queue; only reset clears the perf counter.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    if (rst) bubble_cnt_q <= '0;
    else     bubble_cnt_q <= bubble_cnt_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= bus.imem_inst;
      pc_mem[wr_ptr_q]   <= bus.imem_pc;
    end
  end
endmodule

// File: tb/tb_ama_riscv_fetch_buf.sv
// Directed self-checking bench for ama_riscv_fetch_buf (DEPTH=2).
module tb_ama_riscv_fetch_buf;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bubble_cnt;
  int          testsRun = 0;
  int          testsFailed = 0;

  ama_riscv_fetch_buf_if bus ();

  ama_riscv_fetch_buf #(.DEPTH(2), .NOP_INST(32'h0000_0013)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] inst,
                               input logic [31:0] pc, input logic rdy,
                               input logic fl);
    bus.imem_valid = valid;
    bus.imem_inst  = inst;
    bus.imem_pc    = pc;
    bus.id_ready   = rdy;
    bus.flush      = fl;
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
    checkOutput("rst_id_inst", bus.id_inst, 32'h0000_0013);
    checkOutput("rst_id_pc", bus.id_pc, 32'h0);
    checkOutput("rst_imem_ready", {31'b0, bus.imem_ready}, 32'd0);
    checkOutput("rst_bubble", bubble_cnt, 32'd0);

    // Test 1: back-to-back A, B with decode always ready
    rst = 1'b0;
    #1;
    checkOutput("t1_ready_after_rst", {31'b0, bus.imem_ready}, 32'd1);
    applyStimulus(1'b1, 32'hAAAA_0001, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("t1_a_valid", {31'b0, bus.id_valid}, 32'd1);
    checkOutput("t1_a_inst", bus.id_inst, 32'hAAAA_0001);
    checkOutput("t1_a_pc", bus.id_pc, 32'h0);
    applyStimulus(1'b1, 32'hBBBB_0002, 32'h4, 1'b1, 1'b0);
    tick();
    checkOutput("t1_b_valid", {31'b0, bus.id_valid}, 32'd1);
    checkOutput("t1_b_inst", bus.id_inst, 32'hBBBB_0002);
    checkOutput("t1_b_pc", bus.id_pc, 32'h4);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("t1_drained", {31'b0, bus.id_valid}, 32'd0);
    checkOutput("t1_nop", bus.id_inst, 32'h0000_0013);

    // Test 2: stall with three offered words, then release
    applyStimulus(1'b1, 32'hCCCC_0003, 32'h8, 1'b0, 1'b0);
    tick();
    checkOutput("t2_c_inst", bus.id_inst, 32'hCCCC_0003);
    checkOutput("t2_ready_c1", {31'b0, bus.imem_ready}, 32'd1);
    applyStimulus(1'b1, 32'hDDDD_0004, 32'hC, 1'b0, 1'b0);
    tick();
    checkOutput("t2_full_ready", {31'b0, bus.imem_ready}, 32'd0);
    checkOutput("t2_hold_inst", bus.id_inst, 32'hCCCC_0003);
    applyStimulus(1'b1, 32'hEEEE_0005, 32'h10, 1'b0, 1'b0);
    tick();
    checkOutput("t2_still_full", {31'b0, bus.imem_ready}, 32'd0);
    checkOutput("t2_hold_pc", bus.id_pc, 32'h8);
    applyStimulus(1'b1, 32'hEEEE_0005, 32'h10, 1'b1, 1'b0);
    tick();
    checkOutput("t2_d_inst", bus.id_inst, 32'hDDDD_0004);
    checkOutput("t2_d_pc", bus.id_pc, 32'hC);
    checkOutput("t2_ready_after_pop", {31'b0, bus.imem_ready}, 32'd1);
    tick();
    checkOutput("t2_e_inst", bus.id_inst, 32'hEEEE_0005);
    checkOutput("t2_e_pc", bus.id_pc, 32'h10);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("t2_drained", {31'b0, bus.id_valid}, 32'd0);

    // Test 3: flush a full buffer while a word is offered
    applyStimulus(1'b1, 32'hF0F0_0006, 32'h20, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'hF1F1_0007, 32'h24, 1'b0, 1'b0);
    tick();
    checkOutput("t3_full", {31'b0, bus.imem_ready}, 32'd0);
    applyStimulus(1'b1, 32'hF2F2_0008, 32'h28, 1'b0, 1'b1);
    tick();
    checkOutput("t3_valid", {31'b0, bus.id_valid}, 32'd0);
    checkOutput("t3_inst", bus.id_inst, 32'h0000_0013);
    checkOutput("t3_pc", bus.id_pc, 32'h0);
    checkOutput("t3_ready", {31'b0, bus.imem_ready}, 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("t3_flushed_word_absent", {31'b0, bus.id_valid}, 32'd0);

    // Test 4: steady push+pop at count=1 for 10 cycles
    applyStimulus(1'b1, 32'hA000_0000, 32'h0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("t4_pc_%0d", i), bus.id_pc, 32'(4 * i));
      checkOutput($sformatf("t4_inst_%0d", i), bus.id_inst,
                  32'hA000_0000 | 32'(4 * i));
      checkOutput($sformatf("t4_ready_%0d", i), {31'b0, bus.imem_ready}, 32'd1);
      applyStimulus(1'b1, 32'hA000_0000 | 32'(4 * (i + 1)), 32'(4 * (i + 1)),
                    1'b1, 1'b0);
      tick();
    end
    checkOutput("t4_count_one", {31'b0, bus.id_valid}, 32'd1);
    checkOutput("t4_last_pc", bus.id_pc, 32'h28);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("t4_drained", {31'b0, bus.id_valid}, 32'd0);

    // Test 5: bubble counting then reset
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("t5_bubble_clr", bubble_cnt, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("t5_bubble_5", bubble_cnt, 32'd5);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_ready", {31'b0, bus.imem_ready}, 32'd0);
    checkOutput("t5_rst_valid", {31'b0, bus.id_valid}, 32'd0);
    tick();
    checkOutput("t5_bubble_0", bubble_cnt, 32'd0);
    rst = 1'b0;

    // Test 6: perf counter wraps
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_q;
    checkOutput("t6_preload", bubble_cnt, 32'hFFFF_FFFF);
    tick();
    checkOutput("t6_wrap", bubble_cnt, 32'd0);
    tick();
    checkOutput("t6_after_wrap", bubble_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
